// File: rtl/mem_read_responder_if.sv
// Cache-fill request/response bundle between a fill requester (master) and
// the memory responder (slave).
interface mem_read_responder_if;
  // Handshake: a request is accepted on every rising edge with enable=1 (there
  // is no ready/backpressure); each accepted read returns exactly one
  // data_valid pulse, in issue order, a fixed number of cycles later.
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic [3:0]  outstanding;
  logic        busy;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, outstanding, busy
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, outstanding, busy
  );
endinterface

// File: rtl/mem_read_responder.sv
// Fully pipelined fixed-latency main-memory model: one word request per cycle,
// read data returned through a LATENCY-deep {valid, data} shift pipeline.
module mem_read_responder #(
  parameter int LATENCY   = 4,
  parameter int ADDR_BITS = 10,
  parameter int DATA_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_read_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [ADDR_BITS-1:0] word_idx;
  logic                 rd_req;
  logic                 wr_req;
  logic                 unused_addr_bits;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [DATA_W-1:0]  dat_q [LATENCY];
  logic [DATA_W-1:0]  dat_d [LATENCY];
  logic [3:0]         outstanding_q, outstanding_d;

  // Byte address: bit 0 and bits above the word index alias onto the same word.
  assign word_idx         = bus.addr[ADDR_BITS:1];
  assign unused_addr_bits = ^{bus.addr[15:ADDR_BITS+1], bus.addr[0]};

  assign rd_req = bus.enable & ~bus.wr;
  assign wr_req = bus.enable &  bus.wr;

  always_comb begin
    vld_d[0] = rd_req;
    dat_d[0] = mem_q[word_idx];
    for (int k = 1; k < LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      dat_d[k] = dat_q[k-1];
    end
    // The last stage doubles as the data_out register, which holds between pulses.
    if (!vld_d[LATENCY-1]) begin
      dat_d[LATENCY-1] = dat_q[LATENCY-1];
    end

    outstanding_d = outstanding_q;
    case ({rd_req, vld_q[LATENCY-1]})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q         <= '0;
      outstanding_q <= '0;
      for (int k = 0; k < LATENCY; k++) begin
        dat_q[k] <= '0;
      end
    end else begin
      vld_q         <= vld_d;
      outstanding_q <= outstanding_d;
      for (int k = 0; k < LATENCY; k++) begin
        dat_q[k] <= dat_d[k];
      end
    end
  end

  // Storage survives reset; a write presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_req) begin
      mem_q[word_idx] <= bus.data_in;
    end
  end

  assign bus.data_valid  = vld_q[LATENCY-1];
  assign bus.data_out    = dat_q[LATENCY-1];
  assign bus.outstanding = outstanding_q;
  assign bus.busy        = |outstanding_q;

endmodule

// File: tb/tb_mem_read_responder.sv
// Bench for mem_read_responder: directed fill/hazard/reset/alias sequences plus
// random traffic, checked every cycle against a queue-based memory model.
module tb_mem_read_responder;

  localparam int LAT = 4;
  localparam int AB  = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_read_responder_if bus();

  mem_read_responder #(.LATENCY(LAT), .ADDR_BITS(AB), .DATA_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: word array plus queue of pending read results with due edge.
  logic [15:0] ref_mem [1 << AB];
  logic [15:0] exp_q [$];
  int          due_q [$];
  logic [15:0] last_out;
  int          cyc;

  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic en, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
    logic [15:0] exp_out;
    logic        exp_v;
    logic [AB-1:0] widx;
    int          exp_os;
    rst          = r;
    bus.enable   = en;
    bus.wr       = w;
    bus.addr     = a;
    bus.data_in  = d;
    widx         = a[AB:1];
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      due_q.delete();
      last_out = 16'h0000;
    end else if (en && w) begin
      ref_mem[widx] = d;
    end else if (en) begin
      exp_q.push_back(ref_mem[widx]);
      due_q.push_back(cyc + LAT - 1);
    end
    #1;
    exp_os = due_q.size();
    exp_v  = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      exp_v    = 1'b1;
      last_out = exp_q.pop_front();
      void'(due_q.pop_front());
    end
    exp_out = last_out;
    check("data_valid",  {15'b0, bus.data_valid}, {15'b0, exp_v});
    check("data_out",    bus.data_out, exp_out);
    check("outstanding", {12'b0, bus.outstanding}, 16'(exp_os));
    check("busy",        {15'b0, bus.busy}, {15'b0, (exp_os != 0)});
    cyc++;
  endtask

  task automatic wr_op(input logic [15:0] a, input logic [15:0] d);
    cycle(1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd_op(input logic [15:0] a);
    cycle(1'b0, 1'b1, 1'b0, a, 16'(($urandom)));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic reset_op();
    cycle(1'b1, 1'b1, 1'($urandom), 16'($urandom), 16'($urandom));
  endtask

  initial begin
    logic [15:0] a;
    int          op;
    n_vec       = 0;
    n_err       = 0;
    cyc         = 0;
    last_out    = 16'h0000;
    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.wr      = 1'b0;
    bus.addr    = 16'h0000;
    bus.data_in = 16'h0000;

    reset_op();
    reset_op();

    // Fill every word so all later reads have known contents (upper bits alias).
    for (int i = 0; i < (1 << AB); i++) begin
      a       = 16'($urandom);
      a[AB:1] = AB'(i);
      wr_op(a, 16'($urandom));
    end
    idle(LAT + 1);

    // Single read with fixed latency.
    wr_op(16'h0010, 16'hBEEF);
    idle(2);
    rd_op(16'h0010);
    idle(LAT + 2);

    // Back-to-back 8-word line fill.
    for (int i = 0; i < 8; i++) wr_op(16'(16'h0040 + 2 * i), 16'(16'h1000 + i));
    for (int i = 0; i < 8; i++) rd_op(16'(16'h0040 + 2 * i));
    idle(LAT + 2);

    // Read, write, read of the same word.
    wr_op(16'h0020, 16'h0001);
    rd_op(16'h0020);
    wr_op(16'h0020, 16'h0002);
    rd_op(16'h0020);
    idle(LAT + 2);

    // Reset with reads in flight; storage must survive.
    wr_op(16'h0030, 16'h1234);
    rd_op(16'h0030);
    rd_op(16'h0010);
    rd_op(16'h0030);
    idle(1);
    reset_op();
    idle(LAT + 2);
    rd_op(16'h0030);
    idle(LAT + 2);

    // Address aliasing.
    wr_op(16'h0802, 16'hA5A5);
    rd_op(16'h0003);
    idle(LAT + 2);

    // Irregular issue spacing.
    rd_op(16'h0010);
    idle(2);
    rd_op(16'h0040);
    idle(LAT + 2);

    // Random traffic over a small word window with random alias bits.
    for (int i = 0; i < 2000; i++) begin
      a       = 16'($urandom);
      a[AB:1] = AB'($urandom_range(0, 15));
      op      = int'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) reset_op();
      else if (op == 0)               idle(1);
      else if (op == 1)               wr_op(a, 16'($urandom));
      else                            rd_op(a);
    end
    idle(LAT + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
